// File: rtl/lifting_datapath.sv
// Haar-style lifting datapath: pairs samples into detail/approx coefficients and
// ping-pongs approximations between two banks across three decomposition levels.
module lifting_datapath #(
  parameter int WIDTH     = 16,
  parameter int CW        = WIDTH + 2,
  parameter int BUF_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     data_in,
  input  logic                 internal_valid,
  input  logic                 data_sel,
  input  logic                 level_done,
  output logic [CW-1:0]        approx_out,
  output logic [CW-1:0]        detail_out,
  output logic                 coeff_valid,
  output logic [1:0]           coeff_level,
  output logic                 frame_done,
  output logic                 err
);
  localparam int PW = $clog2(BUF_DEPTH + 1);
  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

  typedef enum logic [1:0] {L0 = 2'd0, L1 = 2'd1, L2 = 2'd2} lvl_e;

  lvl_e state_q, state_d;
  logic wr_bank, rd_bank, last_lvl;

  logic                 phase_q, phase_d;
  logic signed [CW-1:0] even_q, even_d;
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                 err_q, err_d;
  logic [CW-1:0]        approx_q, detail_q;
  logic [1:0]           coeff_level_q;
  logic                 coeff_valid_q, frame_done_q;

  logic signed [CW-1:0] bank_q [2][BUF_DEPTH];

  logic                 rd_ovf, wr_ovf, pair_done, rd_acc;
  logic signed [CW-1:0] sample, d_c, a_c;

  // Level FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= L0;
    else        state_q <= state_d;
  end

  // Level FSM: next state
  always_comb begin
    state_d = state_q;
    if (level_done) begin
      case (state_q)
        L0:      state_d = L1;
        L1:      state_d = L2;
        default: state_d = L0;
      endcase
    end
  end

  // Level FSM: outputs (bank select follows level[0])
  always_comb begin
    wr_bank  = (state_q == L1);
    rd_bank  = ~wr_bank;
    last_lvl = (state_q == L2);
  end

  always_comb begin
    rd_ovf    = (rd_ptr_q == PW'(BUF_DEPTH));
    wr_ovf    = (wr_ptr_q == PW'(BUF_DEPTH));
    rd_acc    = internal_valid & data_sel;
    pair_done = internal_valid & phase_q;
    if (data_sel) sample = rd_ovf ? '0 : bank_q[rd_bank][rd_ptr_q[AW-1:0]];
    else          sample = {{(CW-WIDTH){data_in[WIDTH-1]}}, data_in};
    d_c = sample - even_q;
    a_c = even_q + (d_c >>> 1);
  end

  // The sample of this cycle is resolved under the old level before level_done clears state.
  always_comb begin
    phase_d  = phase_q ^ internal_valid;
    even_d   = (internal_valid & ~phase_q) ? sample : even_q;
    rd_ptr_d = rd_ptr_q + PW'(rd_acc & ~rd_ovf);
    wr_ptr_d = wr_ptr_q + PW'(pair_done & ~wr_ovf);
    err_d    = err_q | (rd_acc & rd_ovf) | (pair_done & wr_ovf) | (level_done & phase_d);
    if (level_done) begin
      phase_d  = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      phase_q       <= 1'b0;
      even_q        <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      err_q         <= 1'b0;
      approx_q      <= '0;
      detail_q      <= '0;
      coeff_level_q <= '0;
      coeff_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      even_q        <= even_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      err_q         <= err_d;
      coeff_valid_q <= pair_done;
      frame_done_q  <= level_done & last_lvl;
      if (pair_done) begin
        approx_q      <= a_c;
        detail_q      <= d_c;
        coeff_level_q <= state_q;
      end
    end
  end

  // Bank storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (reset && pair_done && !wr_ovf)
      bank_q[wr_bank][wr_ptr_q[AW-1:0]] <= a_c;
  end

  assign approx_out  = approx_q;
  assign detail_out  = detail_q;
  assign coeff_valid = coeff_valid_q;
  assign coeff_level = coeff_level_q;
  assign frame_done  = frame_done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_lifting_datapath.sv
// Scoreboard bench for lifting_datapath: stimulus pushes hand-computed pairs,
// a negedge monitor pops and compares each presented coefficient pair.
module tb_lifting_datapath;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] data_in = '0;
  logic        internal_valid = 1'b0;
  logic        data_sel = 1'b0;
  logic        level_done = 1'b0;
  logic [17:0] approx_out, detail_out;
  logic        coeff_valid, frame_done, err;
  logic [1:0]  coeff_level;

  lifting_datapath dut (
    .clk(clk), .reset(reset), .data_in(data_in), .internal_valid(internal_valid),
    .data_sel(data_sel), .level_done(level_done), .approx_out(approx_out),
    .detail_out(detail_out), .coeff_valid(coeff_valid), .coeff_level(coeff_level),
    .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { int lvl; int d; int a; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0, fd_cnt = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int l, input int d, input int a);
    exp_t e;
    e.lvl = l; e.d = d; e.a = a;
    q.push_back(e);
  endtask

  // One clock of stimulus; returns at posedge+1 with inputs idle.
  task automatic step(input logic iv, input logic sel, input int din, input logic ld);
    internal_valid = iv; data_sel = sel; data_in = 16'(din); level_done = ld;
    @(posedge clk); #1;
    internal_valid = 1'b0; level_done = 1'b0; data_sel = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle(2);
    reset = 1'b1;
  endtask

  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (coeff_valid) begin
      if (q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_valid: got d=%0d a=%0d, expected no output",
                 $signed(detail_out), $signed(approx_out));
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("coeff_level", int'(coeff_level), e.lvl);
        chk("detail_out", int'($signed(detail_out)), e.d);
        chk("approx_out", int'($signed(approx_out)), e.a);
      end
    end
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_approx", int'(approx_out), 0);
    chk("rst_detail", int'(detail_out), 0);
    chk("rst_valid", int'(coeff_valid), 0);
    chk("rst_level", int'(coeff_level), 0);
    chk("rst_frame", int'(frame_done), 0);
    chk("rst_err", int'(err), 0);

    // Full frame: L0 from data_in, L1 and L2 from banks
    push(0, -6, 7);  step(1, 0, 10, 0); step(1, 0, 4, 0);
    push(0, 8, 1);   step(1, 0, -3, 0); step(1, 0, 5, 0);
    push(0, 0, 7);   step(1, 0, 7, 0);  step(1, 0, 7, 0);
    push(0, -1, -1); step(1, 0, 0, 0);  step(1, 0, -1, 0);
    step(0, 0, 0, 1);
    push(1, -6, 4);  step(1, 1, 0, 0); step(1, 1, 0, 0);
    push(1, -8, 3);  step(1, 1, 0, 0); step(1, 1, 0, 0);
    step(0, 0, 0, 1);
    push(2, -1, 3);  step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("frame_before", fd_cnt, 0);
    step(0, 0, 0, 1);
    chk("frame_done_pulse", int'(frame_done), 1);
    idle(3);
    chk("frame_count", fd_cnt, 1);
    chk("err_clean_frame", int'(err), 0);

    // Unpaired sample at level_done; L1 must then start on phase 0
    push(0, 2, 2); step(1, 0, 1, 0); step(1, 0, 3, 0);
    step(1, 0, 100, 0);
    chk("err_before_discard", int'(err), 0);
    step(0, 0, 0, 1);
    chk("err_discard", int'(err), 1);
    push(1, -1, 1); step(1, 1, 0, 0); step(1, 1, 0, 0);
    idle(2);

    // Accept coincident with level_done: pair lands at old level and old bank
    do_reset();
    push(0, -4, 4); step(1, 0, 6, 0); step(1, 0, 2, 1);
    push(1, -3, 2); step(1, 1, 0, 0); step(1, 1, 0, 0);
    idle(2);
    chk("err_coincident", int'(err), 0);

    // Write overflow: fifth pair at L0
    do_reset();
    for (int i = 0; i < 5; i++) begin
      push(0, 2, 2 * i + 1);
      step(1, 0, 2 * i, 0); step(1, 0, 2 * i + 2, 0);
      if (i == 3) chk("err_before_wovf", int'(err), 0);
    end
    chk("err_wovf", int'(err), 1);

    // Read overflow: bank0 holds 1,3,5,7; reads beyond depth yield 0
    do_reset();
    step(0, 0, 0, 1);
    push(1, 2, 2); step(1, 1, 0, 0); step(1, 1, 0, 0);
    push(1, 2, 6); step(1, 1, 0, 0); step(1, 1, 0, 0);
    chk("err_before_rovf", int'(err), 0);
    push(1, 0, 0); step(1, 1, 0, 0);
    chk("err_rovf", int'(err), 1);
    step(1, 1, 0, 0);
    idle(2);

    // Reset between even and odd accepts
    do_reset();
    step(1, 0, 10, 0);
    reset = 1'b0;
    step(1, 0, 4, 0);
    chk("midrst_valid", int'(coeff_valid), 0);
    chk("midrst_approx", int'(approx_out), 0);
    chk("midrst_detail", int'(detail_out), 0);
    chk("midrst_err", int'(err), 0);
    reset = 1'b1;
    idle(1);
    chk("midrst_valid2", int'(coeff_valid), 0);
    push(0, -6, 7); step(1, 0, 10, 0); step(1, 0, 4, 0);

    // Extreme inputs exercise sign extension and CW headroom
    push(0, 65535, -1); step(1, 0, -32768, 0); step(1, 0, 32767, 0);
    idle(3);
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
